// File: rtl/branch_ckpt_table_pkg.sv
// Shared widths and types for the branch checkpoint table.
// Module parameters default to the constants below.
package branch_ckpt_table_pkg;
  localparam int CKPT_NUM      = 4;
  localparam int DEF_NUM_PREG  = 128;
  localparam int DEF_PREG_W    = 7;
  localparam int DEF_NUM_AREG  = 32;
  localparam int DEF_ROB_TAG_W = 5;
  localparam int DEF_FL_PTR_W  = 7;
  localparam int DEF_NUM_WB    = 3;
  localparam int CK_W          = $clog2(CKPT_NUM);

  typedef logic [CK_W-1:0] ckpt_id_t;

  typedef struct packed {
    logic [31:0]                         pc;
    logic [DEF_ROB_TAG_W-1:0]            rob_tag;
    logic [DEF_NUM_AREG*DEF_PREG_W-1:0]  rat;
    logic [DEF_NUM_PREG-1:0]             rdy;
    logic [DEF_FL_PTR_W-1:0]             fl_head;
  } ckpt_snapshot_t;
endpackage

// File: rtl/branch_ckpt_table_if.sv
// Rename / branch FU / CDB / restore signals of the checkpoint table.
interface branch_ckpt_table_if
  import branch_ckpt_table_pkg::*;
#(
  parameter int NUM_CKPT  = CKPT_NUM,
  parameter int NUM_PREG  = DEF_NUM_PREG,
  parameter int PREG_W    = DEF_PREG_W,
  parameter int NUM_AREG  = DEF_NUM_AREG,
  parameter int ROB_TAG_W = DEF_ROB_TAG_W,
  parameter int FL_PTR_W  = DEF_FL_PTR_W,
  parameter int NUM_WB    = DEF_NUM_WB
);
  localparam int IW = $clog2(NUM_CKPT);

  logic                       alloc_valid;
  logic                       alloc_ready;
  logic [31:0]                alloc_pc;
  logic [ROB_TAG_W-1:0]       alloc_rob_tag;
  logic [NUM_AREG*PREG_W-1:0] alloc_rat;
  logic [NUM_PREG-1:0]        alloc_rdy;
  logic [FL_PTR_W-1:0]        alloc_fl_head;
  logic [IW-1:0]              alloc_id;
  logic                       resolve_valid;
  logic [IW-1:0]              resolve_id;
  logic                       resolve_mispredict;
  logic [NUM_WB-1:0]          wb_valid;
  logic [NUM_WB*PREG_W-1:0]   wb_preg;
  logic                       restore_valid;
  logic [31:0]                restore_pc;
  logic [ROB_TAG_W-1:0]       restore_rob_tag;
  logic [NUM_AREG*PREG_W-1:0] restore_rat;
  logic [NUM_PREG-1:0]        restore_rdy;
  logic [FL_PTR_W-1:0]        restore_fl_head;
  logic [IW:0]                occupancy;
  logic                       err;

  modport master (
    output alloc_valid, alloc_pc, alloc_rob_tag, alloc_rat, alloc_rdy, alloc_fl_head,
    output resolve_valid, resolve_id, resolve_mispredict, wb_valid, wb_preg,
    input  alloc_ready, alloc_id, restore_valid, restore_pc, restore_rob_tag,
    input  restore_rat, restore_rdy, restore_fl_head, occupancy, err
  );

  modport slave (
    input  alloc_valid, alloc_pc, alloc_rob_tag, alloc_rat, alloc_rdy, alloc_fl_head,
    input  resolve_valid, resolve_id, resolve_mispredict, wb_valid, wb_preg,
    output alloc_ready, alloc_id, restore_valid, restore_pc, restore_rob_tag,
    output restore_rat, restore_rdy, restore_fl_head, occupancy, err
  );
endinterface

// File: rtl/branch_ckpt_table_ckpt_slot.sv
// One checkpoint slot: live/done control plus a snapshot whose ready
// vector keeps absorbing CDB wakeups while it sits in the table.
module ckpt_slot
  import branch_ckpt_table_pkg::*;
#(
  parameter int NUM_PREG  = DEF_NUM_PREG,
  parameter int PREG_W    = DEF_PREG_W,
  parameter int NUM_AREG  = DEF_NUM_AREG,
  parameter int ROB_TAG_W = DEF_ROB_TAG_W,
  parameter int FL_PTR_W  = DEF_FL_PTR_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic                       set_done,
  input  logic                       kill,
  input  logic                       free,
  input  logic [NUM_PREG-1:0]        wake_mask,
  input  logic [31:0]                wr_pc,
  input  logic [ROB_TAG_W-1:0]       wr_rob_tag,
  input  logic [NUM_AREG*PREG_W-1:0] wr_rat,
  input  logic [NUM_PREG-1:0]        wr_rdy,
  input  logic [FL_PTR_W-1:0]        wr_fl_head,
  output logic                       live,
  output logic                       done,
  output logic [31:0]                pc,
  output logic [ROB_TAG_W-1:0]       rob_tag,
  output logic [NUM_AREG*PREG_W-1:0] rat,
  output logic [NUM_PREG-1:0]        rdy,
  output logic [FL_PTR_W-1:0]        fl_head
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live <= 1'b0;
      done <= 1'b0;
    end else if (wr_en) begin
      live <= 1'b1;
      done <= 1'b0;
    end else if (kill || free) begin
      live <= 1'b0;
      done <= 1'b0;
    end else if (set_done) begin
      done <= 1'b1;
    end
  end

  // Snapshot payload carries no reset; wakeups OR in every cycle, including the write cycle.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc      <= wr_pc;
      rob_tag <= wr_rob_tag;
      rat     <= wr_rat;
      fl_head <= wr_fl_head;
      rdy     <= wr_rdy | wake_mask;
    end else begin
      rdy     <= rdy | wake_mask;
    end
  end
endmodule

// File: rtl/branch_ckpt_table.sv
// In-order circular table of branch checkpoints with in-order retirement
// and single-cycle restore of the mispredicted branch's snapshot.
module branch_ckpt_table
  import branch_ckpt_table_pkg::*;
#(
  parameter int NUM_CKPT  = CKPT_NUM,
  parameter int NUM_PREG  = DEF_NUM_PREG,
  parameter int PREG_W    = DEF_PREG_W,
  parameter int NUM_AREG  = DEF_NUM_AREG,
  parameter int ROB_TAG_W = DEF_ROB_TAG_W,
  parameter int FL_PTR_W  = DEF_FL_PTR_W,
  parameter int NUM_WB    = DEF_NUM_WB
) (
  input logic clk,
  input logic reset,
  branch_ckpt_table_if.slave bus
);
  localparam int IW = $clog2(NUM_CKPT);
  typedef logic [IW:0] ptr_t;

  ptr_t                       head, tail;
  logic [IW-1:0]              head_idx, tail_idx, res_id, res_age;
  logic                       full, mp_req, alloc_fire, res_ok, mp_fire, head_free, err_q;
  logic [NUM_PREG-1:0]        wake_mask;
  logic [NUM_CKPT-1:0]        slot_live, slot_done, slot_wr, slot_set_done, slot_kill, slot_free;
  logic [31:0]                slot_pc      [NUM_CKPT];
  logic [ROB_TAG_W-1:0]       slot_rob_tag [NUM_CKPT];
  logic [NUM_AREG*PREG_W-1:0] slot_rat     [NUM_CKPT];
  logic [NUM_PREG-1:0]        slot_rdy     [NUM_CKPT];
  logic [FL_PTR_W-1:0]        slot_fl_head [NUM_CKPT];

  always_comb begin
    wake_mask = '0;
    for (int k = 0; k < NUM_WB; k++)
      if (bus.wb_valid[k]) wake_mask[bus.wb_preg[k*PREG_W +: PREG_W]] = 1'b1;
  end

  assign head_idx        = head[IW-1:0];
  assign tail_idx        = tail[IW-1:0];
  assign res_id          = bus.resolve_id;
  assign full            = (head_idx == tail_idx) && (head[IW] != tail[IW]);
  assign mp_req          = bus.resolve_valid && bus.resolve_mispredict;
  assign bus.alloc_ready = !full && !mp_req;
  assign bus.alloc_id    = tail_idx;
  assign alloc_fire      = bus.alloc_valid && bus.alloc_ready;
  // A done slot is already resolved; resolving it again is an error like a dead slot.
  assign res_ok          = bus.resolve_valid && slot_live[res_id] && !slot_done[res_id];
  assign mp_fire         = res_ok && bus.resolve_mispredict;
  assign head_free       = slot_live[head_idx] && slot_done[head_idx];
  assign res_age         = res_id - head_idx;
  assign bus.occupancy   = tail - head;
  assign bus.err         = err_q;

  for (genvar i = 0; i < NUM_CKPT; i++) begin : g_slot
    localparam logic [IW-1:0] IDX = IW'(i);
    logic [IW-1:0] age;
    assign age              = IDX - head_idx;
    assign slot_wr[i]       = alloc_fire && (tail_idx == IDX);
    assign slot_set_done[i] = res_ok && !bus.resolve_mispredict && (res_id == IDX);
    // Mispredicted slot and everything younger: age measured from head.
    assign slot_kill[i]     = mp_fire && (age >= res_age);
    assign slot_free[i]     = head_free && (head_idx == IDX);

    ckpt_slot #(
      .NUM_PREG(NUM_PREG), .PREG_W(PREG_W), .NUM_AREG(NUM_AREG),
      .ROB_TAG_W(ROB_TAG_W), .FL_PTR_W(FL_PTR_W)
    ) u_slot (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (slot_wr[i]),
      .set_done   (slot_set_done[i]),
      .kill       (slot_kill[i]),
      .free       (slot_free[i]),
      .wake_mask  (wake_mask),
      .wr_pc      (bus.alloc_pc),
      .wr_rob_tag (bus.alloc_rob_tag),
      .wr_rat     (bus.alloc_rat),
      .wr_rdy     (bus.alloc_rdy),
      .wr_fl_head (bus.alloc_fl_head),
      .live       (slot_live[i]),
      .done       (slot_done[i]),
      .pc         (slot_pc[i]),
      .rob_tag    (slot_rob_tag[i]),
      .rat        (slot_rat[i]),
      .rdy        (slot_rdy[i]),
      .fl_head    (slot_fl_head[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      err_q <= 1'b0;
    end else begin
      if (head_free) head <= head + ptr_t'(1);
      // Rebuilding tail from head keeps the wrap bit coherent after a flush.
      if (mp_fire)         tail <= head + ptr_t'(res_age);
      else if (alloc_fire) tail <= tail + ptr_t'(1);
      if (bus.resolve_valid && !res_ok) err_q <= 1'b1;
    end
  end

  // Restore stage: snapshot plus same-cycle wakeups, presented one cycle after the mispredict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.restore_valid   <= 1'b0;
      bus.restore_pc      <= '0;
      bus.restore_rob_tag <= '0;
      bus.restore_rat     <= '0;
      bus.restore_rdy     <= '0;
      bus.restore_fl_head <= '0;
    end else begin
      bus.restore_valid <= mp_fire;
      if (mp_fire) begin
        bus.restore_pc      <= slot_pc[res_id];
        bus.restore_rob_tag <= slot_rob_tag[res_id];
        bus.restore_rat     <= slot_rat[res_id];
        bus.restore_rdy     <= slot_rdy[res_id] | wake_mask;
        bus.restore_fl_head <= slot_fl_head[res_id];
      end
    end
  end
endmodule

// File: tb/tb_branch_ckpt_table.sv
// Directed bench for branch_ckpt_table: a vector table for the main
// alloc/resolve/mispredict flow plus sequences for reset, wrap and wakeup.
module tb_branch_ckpt_table;
  localparam int NUM_AREG = 32;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  branch_ckpt_table_if bus ();

  branch_ckpt_table dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        av;
    logic [31:0] pc;
    logic        rv;
    logic [1:0]  rid;
    logic        rmp;
    logic        e_rdy;
    logic [1:0]  e_id;
    logic [2:0]  e_occ;
    logic        e_rvld;
    logic [31:0] e_rpc;
    logic        e_err;
  } vec_t;

  localparam int NV = 25;
  vec_t vec [NV];

  function automatic vec_t mk(input int av, pc, rv, rid, rmp, rdy, id, occ, rvld, rpc, er);
    vec_t v;
    v.av = av[0];     v.pc = pc;          v.rv = rv[0];     v.rid = rid[1:0];
    v.rmp = rmp[0];   v.e_rdy = rdy[0];   v.e_id = id[1:0]; v.e_occ = occ[2:0];
    v.e_rvld = rvld[0]; v.e_rpc = rpc;    v.e_err = er[0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_alloc(input logic v, input logic [31:0] pc);
    bus.alloc_valid   = v;
    bus.alloc_pc      = pc;
    bus.alloc_rob_tag = pc[8:4];
    bus.alloc_rat     = {NUM_AREG{pc[10:4]}};
    bus.alloc_rdy     = '1;
    bus.alloc_fl_head = pc[10:4] + 7'd1;
  endtask

  task automatic res(input logic v, input int id, input logic mp);
    bus.resolve_valid      = v;
    bus.resolve_id         = id[1:0];
    bus.resolve_mispredict = mp;
  endtask

  task automatic idle();
    drive_alloc(1'b0, 32'h0);
    res(1'b0, 0, 1'b0);
    bus.wb_valid = '0;
    bus.wb_preg  = '0;
  endtask

  initial begin
    //          av pc     rv id mp | rdy id occ rvld rpc    err
    vec[ 0] = mk(1, 'h10, 0, 0, 0,   1,  0, 0,  0,   0,     0);
    vec[ 1] = mk(1, 'h20, 0, 0, 0,   1,  1, 1,  0,   0,     0);
    vec[ 2] = mk(1, 'h30, 0, 0, 0,   1,  2, 2,  0,   0,     0);
    vec[ 3] = mk(1, 'h40, 0, 0, 0,   1,  3, 3,  0,   0,     0);
    vec[ 4] = mk(1, 'h50, 0, 0, 0,   0,  0, 4,  0,   0,     0);
    vec[ 5] = mk(0, 0,    1, 2, 0,   0,  0, 4,  0,   0,     0);
    vec[ 6] = mk(0, 0,    1, 1, 0,   0,  0, 4,  0,   0,     0);
    vec[ 7] = mk(0, 0,    1, 0, 0,   0,  0, 4,  0,   0,     0);
    vec[ 8] = mk(0, 0,    0, 0, 0,   0,  0, 4,  0,   0,     0);
    vec[ 9] = mk(0, 0,    0, 0, 0,   1,  0, 3,  0,   0,     0);
    vec[10] = mk(0, 0,    0, 0, 0,   1,  0, 2,  0,   0,     0);
    vec[11] = mk(0, 0,    0, 0, 0,   1,  0, 1,  0,   0,     0);
    vec[12] = mk(1, 'h50, 0, 0, 0,   1,  0, 1,  0,   0,     0);
    vec[13] = mk(1, 'h60, 0, 0, 0,   1,  1, 2,  0,   0,     0);
    vec[14] = mk(1, 'h70, 0, 0, 0,   1,  2, 3,  0,   0,     0);
    vec[15] = mk(1, 'h80, 1, 1, 1,   0,  3, 4,  0,   0,     0);
    vec[16] = mk(1, 'h90, 0, 0, 0,   1,  1, 2,  1,   'h60,  0);
    vec[17] = mk(0, 0,    0, 0, 0,   1,  2, 3,  0,   0,     0);
    vec[18] = mk(0, 0,    1, 2, 0,   1,  2, 3,  0,   0,     0);
    vec[19] = mk(0, 0,    0, 0, 0,   1,  2, 3,  0,   0,     1);
    vec[20] = mk(0, 0,    1, 3, 0,   1,  2, 3,  0,   0,     1);
    vec[21] = mk(0, 0,    1, 0, 0,   1,  2, 3,  0,   0,     1);
    vec[22] = mk(0, 0,    1, 1, 0,   1,  2, 2,  0,   0,     1);
    vec[23] = mk(0, 0,    0, 0, 0,   1,  2, 1,  0,   0,     1);
    vec[24] = mk(0, 0,    0, 0, 0,   1,  2, 0,  0,   0,     1);

    reset = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_restore_valid", bus.restore_valid, 0);
    chk("rst_occupancy", bus.occupancy, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_restore_pc", bus.restore_pc, 0);
    chk("rst_alloc_ready", bus.alloc_ready, 1);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive_alloc(vec[i].av, vec[i].pc);
      res(vec[i].rv, vec[i].rid, vec[i].rmp);
      #1;
      chk($sformatf("row%0d_alloc_ready", i), bus.alloc_ready, vec[i].e_rdy);
      chk($sformatf("row%0d_alloc_id", i), bus.alloc_id, vec[i].e_id);
      chk($sformatf("row%0d_occupancy", i), bus.occupancy, vec[i].e_occ);
      chk($sformatf("row%0d_restore_valid", i), bus.restore_valid, vec[i].e_rvld);
      chk($sformatf("row%0d_err", i), bus.err, vec[i].e_err);
      if (vec[i].e_rvld) begin
        chk($sformatf("row%0d_restore_pc", i), bus.restore_pc, vec[i].e_rpc);
        chk($sformatf("row%0d_restore_rob_tag", i), bus.restore_rob_tag, vec[i].e_rpc[8:4]);
      end
    end

    // Asynchronous reset in the middle of a cycle with a live slot and err set.
    @(negedge clk);
    idle();
    drive_alloc(1'b1, 32'hC0);
    #1;
    chk("mid_alloc_id", bus.alloc_id, 2);
    @(negedge clk);
    idle();
    #1;
    chk("mid_occupancy", bus.occupancy, 1);
    chk("mid_err", bus.err, 1);
    #1;
    reset = 1'b0;
    #1;
    chk("async_rst_occupancy", bus.occupancy, 0);
    chk("async_rst_err", bus.err, 0);
    chk("async_rst_restore_pc", bus.restore_pc, 0);
    chk("async_rst_restore_rob_tag", bus.restore_rob_tag, 0);
    chk("async_rst_restore_fl_head", bus.restore_fl_head, 0);
    chk("async_rst_alloc_id", bus.alloc_id, 0);
    @(negedge clk);
    reset = 1'b1;

    // Three fill/drain rounds: ids wrap 0..3 each time.
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        res(1'b0, 0, 1'b0);
        drive_alloc(1'b1, 32'h200 + r * 64 + j * 16);
        #1;
        chk($sformatf("wrap%0d_id%0d", r, j), bus.alloc_id, j);
        chk($sformatf("wrap%0d_ready%0d", r, j), bus.alloc_ready, 1);
        chk($sformatf("wrap%0d_occ%0d", r, j), bus.occupancy, j);
      end
      @(negedge clk);
      drive_alloc(1'b0, 32'h0);
      #1;
      chk($sformatf("wrap%0d_full_ready", r), bus.alloc_ready, 0);
      chk($sformatf("wrap%0d_full_occ", r), bus.occupancy, 4);
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        res(1'b1, j, 1'b0);
      end
      @(negedge clk);
      res(1'b0, 0, 1'b0);
      for (int w = 0; w < 8 && bus.occupancy != 0; w++) @(negedge clk);
      #1;
      chk($sformatf("wrap%0d_empty_occ", r), bus.occupancy, 0);
      chk($sformatf("wrap%0d_empty_ready", r), bus.alloc_ready, 1);
    end

    // Wakeups: same-cycle with allocation (41), later (40), never (42).
    @(negedge clk);
    idle();
    drive_alloc(1'b1, 32'h100);
    bus.alloc_rdy[42:40] = 3'b000;
    bus.wb_valid = 3'b001;
    bus.wb_preg[6:0] = 7'd41;
    #1;
    chk("wake_alloc_id", bus.alloc_id, 0);
    @(negedge clk);
    idle();
    bus.wb_valid = 3'b010;
    bus.wb_preg[13:7] = 7'd40;
    @(negedge clk);
    idle();
    res(1'b1, 0, 1'b1);
    drive_alloc(1'b1, 32'h300);
    #1;
    chk("mp_alloc_ready", bus.alloc_ready, 0);
    @(negedge clk);
    idle();
    #1;
    chk("wake_restore_valid", bus.restore_valid, 1);
    chk("wake_rdy40", bus.restore_rdy[40], 1);
    chk("wake_rdy41", bus.restore_rdy[41], 1);
    chk("wake_rdy42", bus.restore_rdy[42], 0);
    chk("wake_rdy0", bus.restore_rdy[0], 1);
    chk("wake_restore_pc", bus.restore_pc, 32'h100);
    chk("wake_restore_rob_tag", bus.restore_rob_tag, 5'h10);
    chk("wake_restore_fl_head", bus.restore_fl_head, 7'h11);
    chk("wake_restore_rat5", bus.restore_rat[35 +: 7], 7'h10);
    chk("wake_occupancy", bus.occupancy, 0);
    @(negedge clk);
    #1;
    chk("restore_pulse_len", bus.restore_valid, 0);
    chk("dropped_alloc_occ", bus.occupancy, 0);
    chk("dropped_alloc_id", bus.alloc_id, 0);

    // Second correct resolve of an already-done slot.
    @(negedge clk);
    drive_alloc(1'b1, 32'h400);
    @(negedge clk);
    drive_alloc(1'b0, 32'h0);
    res(1'b1, 0, 1'b0);
    @(negedge clk);
    res(1'b1, 0, 1'b0);
    #1;
    chk("dbl_err_before", bus.err, 0);
    @(negedge clk);
    idle();
    #1;
    chk("dbl_err_set", bus.err, 1);
    @(negedge clk);
    #1;
    chk("dbl_err_sticky", bus.err, 1);
    chk("dbl_occupancy", bus.occupancy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_ckpt_table.md
# branch_ckpt_table

Multi-entry branch checkpoint table that replaces the single-snapshot checkpoint in the out-of-order core. It sits between rename (allocation on each renamed branch), the branch FU/ROB (resolution and mispredict), and rename/PRF/free list (state restore). It holds up to NUM_CKPT in-flight branch snapshots in program order. Each stored ready vector is kept current with CDB wakeups, so a restore never re-marks completed older results as busy.

## Interface
Parameters:
- NUM_CKPT, 4: checkpoint slots; power of two, ≥2.
- NUM_PREG, 128: physical registers; width of the ready vector.
- PREG_W, 7: physical register index width.
- NUM_AREG, 32: architectural registers in the RAT snapshot.
- ROB_TAG_W, 5: ROB tag width.
- FL_PTR_W, 7: free-list head pointer width.
- NUM_WB, 3: CDB writeback ports (ALU, branch, mem).

Ports (CK_W = clog2(NUM_CKPT)):
- clk, in, 1: clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-low.
- alloc_valid, in, 1: rename presents a branch snapshot.
- alloc_ready, out, 1: slot available.
- alloc_pc, in, 32: branch PC.
- alloc_rob_tag, in, ROB_TAG_W: branch ROB tag.
- alloc_rat, in, NUM_AREG*PREG_W: flat map-table snapshot; entry i occupies bits [i*PREG_W +: PREG_W].
- alloc_rdy, in, NUM_PREG: PRF ready vector.
- alloc_fl_head, in, FL_PTR_W: free-list head pointer.
- alloc_id, out, CK_W: slot index assigned this cycle; travels with the branch.
- resolve_valid, in, 1: branch FU resolves a checkpoint.
- resolve_id, in, CK_W: checkpoint being resolved.
- resolve_mispredict, in, 1: 1 means restore; 0 means the prediction was correct.
- wb_valid, in, NUM_WB: CDB valid bits.
- wb_preg, in, NUM_WB*PREG_W: CDB destination registers.
- restore_valid, out, 1: one-cycle restore pulse.
- restore_pc, out, 32: PC of the mispredicted branch.
- restore_rob_tag, out, ROB_TAG_W: ROB tag of the mispredicted branch.
- restore_rat, out, NUM_AREG*PREG_W: map table to restore.
- restore_rdy, out, NUM_PREG: ready vector to restore.
- restore_fl_head, out, FL_PTR_W: free-list head to restore.
- occupancy, out, CK_W+1: number of live checkpoints.
- err, out, 1: sticky flag for a resolve on a non-live slot.

## Operation
- Slots form a circular buffer. head is the oldest live slot and tail the next free slot. Both pointers are CK_W+1 bits wide with a wrap bit. full means equal indices with differing wrap bits. empty means the pointers are equal.
- alloc_ready = !full && !(resolve_valid && resolve_mispredict). The table accepts an allocation when alloc_valid && alloc_ready. On accept it writes the slot at tail, sets live=1 and done=0, sets alloc_id = tail index (combinational), and increments tail.
- Wakeup: each valid CDB port sets bit wb_preg[k] in the ready vector of every live slot. The wakeup also applies to the slot being allocated in the same cycle, so the stored vector is alloc_rdy with the CDB bits ORed in.
- Correct resolve: sets done on a live resolve_id. When the head slot is live and done, it is freed (live=0) and head increments. Only one slot is freed per cycle, so out-of-order resolves drain in order.
- Mispredict resolve on live slot id:
  - registers restore_* from slot id, with same-cycle wakeups ORed into restore_rdy;
  - clears live on slot id and on every younger slot (id through tail-1);
  - sets tail = id, keeping the wrap bit consistent so head/tail arithmetic stays correct.
  - A simultaneous allocation is dropped.
- A resolve on a non-live slot is ignored and sets err.
- A mispredict on a slot that is also being head-freed cannot occur, because done requires a prior correct resolve. A second resolve on the same id sets err.
- occupancy = tail - head (modulo 2^(CK_W+1)).

## Timing
- Reset (reset=0, asynchronous): all live and done bits = 0; head = tail = 0; restore_valid = 0; every restore_* field = 0; occupancy = 0; err = 0. alloc_ready = 1 from the first cycle after release.
- Allocation latency: the slot is resolvable in the next cycle. alloc_ready reflects the occupancy of the current cycle.
- Restore latency: restore_valid is high exactly one cycle after the mispredict input, for one cycle. An allocation in that cycle is accepted into the restored tail slot.
- Head free latency: 1 cycle after done is set at the head slot; then 1 slot per cycle.
- Pointer wrap: index NUM_CKPT-1 wraps to index 0 and toggles the wrap bit.

## Structure
- types_pkg additions:
  - ckpt_id_t, logic [CK_W-1:0];
  - ckpt_snapshot_t, a struct of pc, rob_tag, rat, rdy, fl_head;
  - the CKPT_NUM constant default.
- Sub-module ckpt_slot: one storage slot holding live, done and the snapshot, with the wakeup OR logic. The top instantiates NUM_CKPT slots and adds the pointers, the resolve decode and the restore mux.

## Test plan
- Reset sequence, then 4 allocations (PCs 0x10, 0x20, 0x30, 0x40) -> alloc_id = 0,1,2,3; alloc_ready=0 after the fourth; occupancy=4; a fifth allocation is not accepted.
- Correct resolves of ids 2, 1, 0 in that order -> head advances only after id 0 is resolved, then frees 0, 1, 2 on successive cycles; occupancy goes 4→3→2→1.
- Allocate ids 0–2, then mispredict id 1 -> next cycle restore_valid=1 with restore_pc=0x20 and the stored rob_tag; slots 1 and 2 freed; occupancy=1; the next allocation gets alloc_id=1.
- Allocate with alloc_rdy bit 40 = 0, then wb_valid[1]=1 with wb_preg=40, then mispredict that slot -> restore_rdy[40]=1. Same-cycle wakeup together with the allocation -> stored bit is 1.
- Repeated alloc/resolve across 3 wraps -> ids cycle 0..3,0..; full and empty are correct at every wrap; mispredict and allocation in the same cycle -> allocation dropped.
- Resolve of id 3 with no live slot 3 -> state unchanged, err=1 and stays 1. Asserting reset mid-operation -> all outputs return to their reset values at once.
